// File: rtl/updown_counter.sv
// Parametrised up/down counter with terminal value, clamped load and cascadable ripple carry.
// Define UPDOWN_COUNTER_SAT_EN to hold at the limits instead of wrapping.
module updown_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             term_c;

  // Terminal value depends on direction; drives rco with zero latency.
  always_comb begin
    term_c = up ? (count_q == MAX_V) : (count_q == '0);
  end

  assign rco = en & term_c;

  // Next count: load (clamped) beats enable; the terminal step never relies on overflow.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (din > MAX_V) ? MAX_V : din;
    end else if (en) begin
      wrap_d = term_c;
      if (term_c) begin
`ifdef UPDOWN_COUNTER_SAT_EN
        count_d = count_q;
`else
        count_d = up ? '0 : MAX_V;
`endif
      end else begin
        count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: MAX=9 stage, cascaded second stage, full-range instance.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       clr, en, up, load;
  logic [3:0] din;
  logic [3:0] q0, q1, qf;
  logic       rco0, rco1, rcof;
  logic       wrap0, wrap1, wrapf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MAX(9)) u_stage0 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
    .q(q0), .rco(rco0), .wrap(wrap0)
  );

  // Second decade of a BCD chain, carried in from stage 0.
  updown_counter #(.WIDTH(4), .MAX(9)) u_stage1 (
    .clk(clk), .clr(clr), .en(rco0), .up(up), .load(1'b0), .din(4'd0),
    .q(q1), .rco(rco1), .wrap(wrap1)
  );

  updown_counter #(.WIDTH(4)) u_full (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
    .q(qf), .rco(rcof), .wrap(wrapf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wrap1_cnt;
    int exp_q;
    clr  = 1'b1;
    en   = 1'b0;
    up   = 1'b1;
    load = 1'b0;
    din  = 4'd0;
    #3;
    check("rst_q", 32'(q0), 0);
    check("rst_wrap", 32'(wrap0), 0);
    check("rst_rco_up", 32'(rco0), 0);
    en = 1'b1;
    up = 1'b0;
    #1;
    check("rst_rco_down", 32'(rco0), 1);
    up = 1'b1;

    // Count up 12 cycles from zero.
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
`ifdef UPDOWN_COUNTER_SAT_EN
      exp_q = (i > 9) ? 9 : i;
      check("up_wrap", 32'(wrap0), (i >= 10) ? 1 : 0);
`else
      exp_q = i % 10;
      check("up_wrap", 32'(wrap0), (i == 10) ? 1 : 0);
`endif
      check("up_q", 32'(q0), 32'(exp_q));
      check("up_rco", 32'(rco0), (exp_q == 9) ? 1 : 0);
      step();
    end

    en = 1'b0;
    step();
`ifdef UPDOWN_COUNTER_SAT_EN
    check("hold_q", 32'(q0), 9);
`else
    check("hold_q", 32'(q0), 2);
`endif
    check("hold_wrap", 32'(wrap0), 0);

    // Down from zero.
    load = 1'b1; din = 4'd0; en = 1'b1;
    step();
    check("ld0_q", 32'(q0), 0);
    check("ld0_wrap", 32'(wrap0), 0);
    load = 1'b0; up = 1'b0;
    #1;
    check("dn_rco_at0", 32'(rco0), 1);
    step();
`ifdef UPDOWN_COUNTER_SAT_EN
    check("dn_q", 32'(q0), 0);
`else
    check("dn_q", 32'(q0), 9);
`endif
    check("dn_wrap", 32'(wrap0), 1);

    load = 1'b1; din = 4'd9;
    step();
    check("ld9_wrap", 32'(wrap0), 0);
    load = 1'b0;
    #1;
    check("dn_rco_at9", 32'(rco0), 0);
    step();
    check("dn_q8", 32'(q0), 8);
    check("dn_wrap8", 32'(wrap0), 0);

    // Direction change takes effect at the next edge.
    up = 1'b1;
    step();
    check("dir_q9", 32'(q0), 9);
    check("dir_rco_up", 32'(rco0), 1);
    up = 1'b0;
    #1;
    check("dir_rco_dn", 32'(rco0), 0);

    // Load beats enable at a terminal value, with clamping.
    up = 1'b1; load = 1'b1; din = 4'hC;
    #1;
    check("ldc_rco_pre", 32'(rco0), 1);
    step();
    check("ldc_q", 32'(q0), 9);
    check("ldc_wrap", 32'(wrap0), 0);
    check("ldc_full_q", 32'(qf), 12);
    din = 4'd5;
    step();
    check("ld5_q", 32'(q0), 5);

    // Asynchronous clear mid-cycle.
    din = 4'd7;
    step();
    check("ld7_q", 32'(q0), 7);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    check("aclr_q", 32'(q0), 0);
    check("aclr_wrap", 32'(wrap0), 0);
    step();
    check("clr_hold_q", 32'(q0), 0);
    @(negedge clk);
    clr = 1'b0;
    step();
    check("resume_q", 32'(q0), 1);
    check("resume_wrap", 32'(wrap0), 0);

    // Cascade of two decades plus full-range instance over 100 cycles.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wrap1_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (wrap1 === 1'b1) wrap1_cnt++;
      if (c == 15) begin
        check("full_q15", 32'(qf), 15);
        check("full_rco15", 32'(rcof), 1);
      end
      if (c == 16) begin
`ifdef UPDOWN_COUNTER_SAT_EN
        check("full_q16", 32'(qf), 15);
`else
        check("full_q16", 32'(qf), 0);
`endif
        check("full_wrap16", 32'(wrapf), 1);
      end
      if (c == 99) check("casc_99", 32'({q1, q0}), 32'h99);
      if (c == 100) begin
`ifdef UPDOWN_COUNTER_SAT_EN
        check("casc_100", 32'({q1, q0}), 32'h99);
`else
        check("casc_100", 32'({q1, q0}), 32'h00);
`endif
      end
    end
`ifdef UPDOWN_COUNTER_SAT_EN
    check("casc_wrap1_cnt", 32'(wrap1_cnt), 82);
`else
    check("casc_wrap1_cnt", 32'(wrap1_cnt), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down counter with programmable terminal value, parallel load and cascadable ripple-carry output. It generalises the team's fixed 4-bit enable/clear counter to any width and modulus, adds direction control and load, and registers a wrap-event flag. Instances chain through `rco` into the next stage's `en` to build wide or mixed-radix counters, for example BCD digit chains and timer prescalers.

## Interface
- `WIDTH`, default 4: counter width in bits, 1 or more.
- `MAX`, default `(1<<WIDTH)-1`: terminal count, with 1 ≤ `MAX` ≤ 2^WIDTH−1. The count range is 0..`MAX`.

- `clk`, input, 1: rising-edge clock.
- `clr`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: count enable and cascade carry-in.
- `up`, input, 1: direction; 1 counts up, 0 counts down.
- `load`, input, 1: synchronous parallel load.
- `din`, input, WIDTH: load value.
- `q`, output, WIDTH: current count, registered.
- `rco`, output, 1: ripple carry-out, combinational.
- `wrap`, output, 1: registered one-cycle terminal-event pulse.

## Operation
- Priority, highest first: `clr`, then `load`, then `en`, then hold.
- `clr` high:
  - `q` = 0 and `wrap` = 0 immediately, with no clock needed.
  - Both are held while `clr` is high.
- `load` high at an edge:
  - `q` ← `din` when `din` ≤ `MAX`.
  - `q` ← `MAX` when `din` > `MAX` (clamp).
  - `wrap` ← 0.
  - `en` and `up` are ignored that cycle.
- `en` high and `load` low, counting up (`up`=1):
  - `q` ← `q`+1, or `q` ← 0 when `q` == `MAX`.
- `en` high and `load` low, counting down (`up`=0):
  - `q` ← `q`−1, or `q` ← `MAX` when `q` == 0.
- `en` low and `load` low: `q` holds and `wrap` ← 0.
- Terminal condition, T:
  - T = (`up` & `q`==`MAX`) | (!`up` & `q`==0).
- `rco` = `en` & T.
  - This is a pure function of the current `q`, `en` and `up`.
  - It is independent of `load`.
- `wrap` ← `en` & !`load` & T at each edge.
  - It is high for exactly the cycle following an enabled count taken from the terminal value.
- All arithmetic is modulo `MAX`+1.
  - Intermediate values must never exceed WIDTH bits.
  - This holds for `MAX` = 2^WIDTH−1, where the increment must not rely on overflow beyond WIDTH.
- A direction change mid-count takes effect at the next edge, with no extra cycle.
- Toggling `up` while at a terminal value changes `rco` in the same cycle.

## Timing
- Reset values: `q` = 0, `wrap` = 0. `rco` = `en` & !`up` during reset, because `q` is 0.
- `clr` deassertion is synchronised by the system.
  - The first count can happen at the first rising edge after `clr` falls.
- Latency:
  - `q` updates 1 cycle after `en` or `load` is sampled.
  - `wrap` coincides with the `q` update it describes: `q` = 0 (up) or `MAX` (down), with `wrap` = 1 in the same cycle.
- `rco` has zero latency. It has a combinational path from `en` and `up`.
  - In a cascade, stage N+1 `en` = stage N `rco`.
  - All stages share `clk` and `clr`.
- Continuous counting up with `MAX` = M gives a `wrap` period of exactly M+1 cycles.
- `clr` asserted mid-count, including in the same cycle as `load` or a wrap: `clr` wins, and `wrap` is not produced.
- `load` and `en` high simultaneously at a terminal value: no wrap and no `wrap` pulse. `rco` is still high before the edge.

## Configuration
- `UPDOWN_COUNTER_SAT_EN`
- Macro defined (saturating mode):
  - Counting up at `MAX`, or down at 0, holds `q` instead of wrapping.
  - `rco` and `wrap` keep the same definitions. `wrap` then flags a blocked count attempt at the limit.
  - `wrap` stays high on consecutive cycles while `en` is held at the limit.
- Macro undefined: the modular wrap behaviour above applies.
- Load clamping and priority are identical in both builds.

## Test plan
- WIDTH=4, MAX=9, pulse `clr` then `en`=1, `up`=1 for 12 cycles:
  - `q` = 0,1,…,9,0,1.
  - `rco` = 1 only while `q`=9.
  - `wrap` = 1 only in the cycle `q` first returns to 0.
- Same configuration, `up`=0 from `q`=0 with `en`=1:
  - `q` = 9,8,…
  - `wrap` = 1 in the cycle `q`=9.
  - `rco` = 1 while `q`=0.
- `load`=1 with `din`=4'hC, MAX=9, and `en`=1 in the same cycle:
  - `q` = 9 next cycle.
  - `wrap` = 0.
- Two cascaded instances (MAX=9), stage 0 `en`=1 for 100 cycles:
  - `{q1,q0}` = 9,9 at cycle 99, then 0,0 at cycle 100.
  - Stage 1 `wrap` pulses once.
- Assert `clr` asynchronously mid-cycle at `q`=7:
  - `q` = 0 and `wrap` = 0 before the next edge.
  - Counting resumes at 1 on the first edge after release.
- With `UPDOWN_COUNTER_SAT_EN`, MAX=9, `en`=1, `up`=1 for 12 cycles:
  - `q` sticks at 9.
  - `wrap` = 1 on every cycle after `q` reaches 9.
